// File: rtl/ddr_bw_pkg.sv
// Shared definitions for the DDR bandwidth-test sequencer: FSM state codes,
// transfer mode encodings, reset constants and mode decode helpers.
package ddr_bw_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD   = 3'd1;
  localparam state_t S_WR_GO  = 3'd2;
  localparam state_t S_WR_RUN = 3'd3;
  localparam state_t S_RD_GO  = 3'd4;
  localparam state_t S_RD_RUN = 3'd5;
  localparam state_t S_NEXT   = 3'd6;
  localparam state_t S_ABORT  = 3'd7;

  localparam logic [1:0] MODE_WR    = 2'd0;
  localparam logic [1:0] MODE_RD    = 2'd1;
  localparam logic [1:0] MODE_WR_RD = 2'd2;

  localparam logic [31:0] ADDR_RST = 32'd0;
  localparam logic [15:0] ITER_RST = 16'd0;

  // Mode 3 is reserved and behaves like write-then-read.
  function automatic logic mode_has_wr(input logic [1:0] m);
    return (m == MODE_WR) || (m >= MODE_WR_RD);
  endfunction

  function automatic logic mode_has_rd(input logic [1:0] m);
    return (m == MODE_RD) || (m >= MODE_WR_RD);
  endfunction

endpackage

// File: rtl/ddr_bw_phase_cnt.sv
// Per-phase bookkeeping: counts completion events, counts cycles in the
// phase, accumulates saturating cycles across iterations and flags timeout.
module ddr_bw_phase_cnt
  import ddr_bw_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int SETTLE_CYC = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_clr_i,
  input  logic                 ph_clr_i,
  input  logic                 run_i,
  input  logic                 evt_i,
  input  logic                 idle_i,
  input  logic [31:0]          nburst_i,
  input  logic [CNT_WIDTH-1:0] timeout_i,
  output logic                 done_o,
  output logic                 tmo_o,
  output logic [CNT_WIDTH-1:0] acc_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [31:0]          evt_q;
  logic [31:0]          evt_sum;
  logic [CNT_WIDTH-1:0] ph_q;
  logic [CNT_WIDTH-1:0] ph_nxt;
  logic [CNT_WIDTH-1:0] acc_q;
  logic                 settled;

  // The idle input is only trusted once the engine has had time to leave idle.
  if (SETTLE_CYC == 0) begin : g_nosettle
    assign settled = 1'b1;
  end else begin : g_settle
    assign settled = (ph_q >= CNT_WIDTH'(SETTLE_CYC));
  end

  // Completion includes an event arriving in the current cycle.
  always_comb begin
    evt_sum = evt_q + {31'd0, evt_i};
    ph_nxt  = sat_inc(ph_q);
    done_o  = run_i && (evt_sum == nburst_i) && settled && idle_i;
    tmo_o   = run_i && (timeout_i != '0) && (ph_nxt >= timeout_i);
  end

  // Event counter: cleared at phase launch, counts handshakes only while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                evt_q <= '0;
    else if (ph_clr_i)      evt_q <= '0;
    else if (run_i && evt_i) evt_q <= evt_sum;
  end

  // Phase cycle counter used for timeout and idle settling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ph_q <= '0;
    else if (ph_clr_i) ph_q <= '0;
    else if (run_i)    ph_q <= ph_nxt;
  end

  // Saturating accumulator of running cycles over all iterations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            acc_q <= '0;
    else if (acc_clr_i) acc_q <= '0;
    else if (run_i)     acc_q <= sat_inc(acc_q);
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ddr_bw_seq.sv
// Sequencer for the DDR bandwidth-test AXI master: launches write/read
// phases, snoops completion, iterates with an address stride, measures
// per-phase cycles and aborts on timeout or request.
module ddr_bw_seq
  import ddr_bw_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int B_BURST_LENGTH = 4,
  parameter int DATA_WIDTH     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [1:0]           cfg_mode,
  input  logic [31:0]          cfg_addr,
  input  logic [31:0]          cfg_nburst,
  input  logic [31:0]          cfg_stride,
  input  logic [15:0]          cfg_niter,
  input  logic [CNT_WIDTH-1:0] cfg_timeout,
  output logic                 WSTART_REG,
  output logic                 RSTART_REG,
  output logic [31:0]          WADDR_REG,
  output logic [31:0]          RADDR_REG,
  output logic [31:0]          WNBURST_REG,
  output logic [31:0]          RNBURST_REG,
  input  logic                 RIDLE_REG,
  input  logic                 bvalid,
  input  logic                 bready,
  input  logic                 rvalid,
  input  logic                 rready,
  input  logic                 rlast,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic [CNT_WIDTH-1:0] wr_cycles,
  output logic [CNT_WIDTH-1:0] rd_cycles,
  output logic [15:0]          iter_cnt
);

  // A zero stride means "tile contiguously": one phase worth of bursts.
  localparam logic [31:0] BYTES_PER_BURST = 32'((1 << B_BURST_LENGTH) * (DATA_WIDTH / 8));

  state_t               state_q, state_d;
  logic [1:0]           mode_q;
  logic [31:0]          nburst_q, stride_q;
  logic [15:0]          niter_q;
  logic [CNT_WIDTH-1:0] tmo_q;
  logic [31:0]          cur_addr_q, cur_addr_d;
  logic [31:0]          addr_out_q, nb_out_q;
  logic [15:0]          iter_q;
  logic                 err_q, done_q;
  logic                 start_ok, tmo_fire;
  logic                 has_wr, has_rd, last_iter;
  logic                 wr_done, wr_tmo, rd_done, rd_tmo;
  logic [31:0]          nb_load;

  assign start_ok  = cfg_start && (state_q == S_IDLE);
  assign has_wr    = mode_has_wr(mode_q);
  assign has_rd    = mode_has_rd(mode_q);
  assign last_iter = ((iter_q + 16'd1) == niter_q);
  assign nb_load   = (state_q == S_IDLE) ? cfg_nburst : nburst_q;

  ddr_bw_phase_cnt #(.CNT_WIDTH(CNT_WIDTH), .SETTLE_CYC(0)) u_wr_cnt (
    .clk      (clk),
    .rst      (rst),
    .acc_clr_i(start_ok),
    .ph_clr_i (state_q == S_WR_GO),
    .run_i    (state_q == S_WR_RUN),
    .evt_i    (bvalid && bready),
    .idle_i   (1'b1),
    .nburst_i (nburst_q),
    .timeout_i(tmo_q),
    .done_o   (wr_done),
    .tmo_o    (wr_tmo),
    .acc_o    (wr_cycles)
  );

  ddr_bw_phase_cnt #(.CNT_WIDTH(CNT_WIDTH), .SETTLE_CYC(2)) u_rd_cnt (
    .clk      (clk),
    .rst      (rst),
    .acc_clr_i(start_ok),
    .ph_clr_i (state_q == S_RD_GO),
    .run_i    (state_q == S_RD_RUN),
    .evt_i    (rvalid && rready && rlast),
    .idle_i   (RIDLE_REG),
    .nburst_i (nburst_q),
    .timeout_i(tmo_q),
    .done_o   (rd_done),
    .tmo_o    (rd_tmo),
    .acc_o    (rd_cycles)
  );

  // Next-state logic; abort beats completion, completion beats timeout.
  always_comb begin
    state_d  = state_q;
    tmo_fire = 1'b0;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_LOAD;
      S_LOAD: begin
        if (cfg_abort)                       state_d = S_ABORT;
        else if (has_wr && nburst_q != '0)   state_d = S_WR_GO;
        else if (has_rd && nburst_q != '0)   state_d = S_RD_GO;
        else                                 state_d = S_NEXT;
      end
      S_WR_GO:  state_d = cfg_abort ? S_ABORT : S_WR_RUN;
      S_WR_RUN: begin
        if (cfg_abort)    state_d = S_ABORT;
        else if (wr_done) state_d = has_rd ? S_RD_GO : S_NEXT;
        else if (wr_tmo) begin
          state_d  = S_ABORT;
          tmo_fire = 1'b1;
        end
      end
      S_RD_GO:  state_d = cfg_abort ? S_ABORT : S_RD_RUN;
      S_RD_RUN: begin
        if (cfg_abort)    state_d = S_ABORT;
        else if (rd_done) state_d = S_NEXT;
        else if (rd_tmo) begin
          state_d  = S_ABORT;
          tmo_fire = 1'b1;
        end
      end
      S_NEXT: begin
        if (cfg_abort)      state_d = S_ABORT;
        else if (last_iter) state_d = S_IDLE;
        else                state_d = S_LOAD;
      end
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Current address: seeded on start, advanced once per completed iteration.
  always_comb begin
    cur_addr_d = cur_addr_q;
    if (start_ok)                cur_addr_d = cfg_addr;
    else if (state_q == S_NEXT)  cur_addr_d = cur_addr_q + stride_q;
  end

  // Shadow copy of the configuration taken when a run is accepted.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      mode_q   <= cfg_mode;
      nburst_q <= cfg_nburst;
      stride_q <= (cfg_stride == '0) ? cfg_nburst * BYTES_PER_BURST : cfg_stride;
      niter_q  <= (cfg_niter == '0) ? 16'd1 : cfg_niter;
      tmo_q    <= cfg_timeout;
    end
  end

  // State, iteration bookkeeping, engine programming and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_addr_q <= ADDR_RST;
      addr_out_q <= ADDR_RST;
      nb_out_q   <= '0;
      iter_q     <= ITER_RST;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      if (state_d == S_LOAD) begin
        addr_out_q <= cur_addr_d;
        nb_out_q   <= nb_load;
      end
      if (start_ok)               iter_q <= ITER_RST;
      else if (state_q == S_NEXT) iter_q <= iter_q + 16'd1;
      if (start_ok)      err_q <= 1'b0;
      else if (tmo_fire) err_q <= 1'b1;
      done_q <= (state_q != S_IDLE) && (state_d == S_IDLE);
    end
  end

  assign WSTART_REG  = (state_q == S_WR_GO);
  assign RSTART_REG  = (state_q == S_RD_GO);
  assign WADDR_REG   = addr_out_q;
  assign RADDR_REG   = addr_out_q;
  assign WNBURST_REG = nb_out_q;
  assign RNBURST_REG = nb_out_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err_timeout = err_q;
  assign iter_cnt    = iter_q;

endmodule

// File: tb/tb_ddr_bw_seq.sv
// Directed bench for ddr_bw_seq with hand-computed expectations.
module tb_ddr_bw_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start, cfg_abort;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_addr, cfg_nburst, cfg_stride;
  logic [15:0] cfg_niter;
  logic [31:0] cfg_timeout;
  logic        WSTART_REG, RSTART_REG;
  logic [31:0] WADDR_REG, RADDR_REG, WNBURST_REG, RNBURST_REG;
  logic        RIDLE_REG, bvalid, bready, rvalid, rready, rlast;
  logic        busy, done, err_timeout;
  logic [31:0] wr_cycles, rd_cycles;
  logic [15:0] iter_cnt;

  ddr_bw_seq #(.CNT_WIDTH(32), .B_BURST_LENGTH(4), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_mode(cfg_mode), .cfg_addr(cfg_addr), .cfg_nburst(cfg_nburst),
    .cfg_stride(cfg_stride), .cfg_niter(cfg_niter), .cfg_timeout(cfg_timeout),
    .WSTART_REG(WSTART_REG), .RSTART_REG(RSTART_REG),
    .WADDR_REG(WADDR_REG), .RADDR_REG(RADDR_REG),
    .WNBURST_REG(WNBURST_REG), .RNBURST_REG(RNBURST_REG),
    .RIDLE_REG(RIDLE_REG), .bvalid(bvalid), .bready(bready),
    .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .wr_cycles(wr_cycles), .rd_cycles(rd_cycles), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int wst_n = 0;
  int rstart_n = 0;
  int done_n = 0;
  logic [31:0] waddr_log[$];

  // Pulse monitor, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (WSTART_REG) begin
      wst_n++;
      waddr_log.push_back(WADDR_REG);
    end
    if (RSTART_REG) rstart_n++;
    if (done) done_n++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_run(input logic [1:0] m, input logic [31:0] a, input logic [31:0] nb,
                           input logic [31:0] st, input logic [15:0] ni, input logic [31:0] to);
    cfg_mode = m; cfg_addr = a; cfg_nburst = nb; cfg_stride = st;
    cfg_niter = ni; cfg_timeout = to; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_pulse(input bit rd, input string tag);
    int i = 0;
    while (((rd ? RSTART_REG : WSTART_REG) == 1'b0) && i < 20) begin
      tick();
      i++;
    end
    chk(tag, rd ? RSTART_REG : WSTART_REG, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic send_b(input int n);
    for (int i = 0; i < n; i++) begin
      bvalid = 1'b1;
      tick();
    end
    bvalid = 1'b0;
  endtask

  task automatic send_r(input int n);
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1; rlast = 1'b1;
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, d0, q0, n;
    rst = 1'b1; cfg_start = 0; cfg_abort = 0; cfg_mode = 0; cfg_addr = 0;
    cfg_nburst = 0; cfg_stride = 0; cfg_niter = 0; cfg_timeout = 0;
    RIDLE_REG = 1; bvalid = 0; bready = 1; rvalid = 0; rready = 1; rlast = 0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wstart", WSTART_REG, 0);
    chk("rst_rstart", RSTART_REG, 0);
    chk("rst_waddr", WADDR_REG, 0);
    chk("rst_rnburst", RNBURST_REG, 0);
    chk("rst_wrcyc", wr_cycles, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;
    tick();

    // Write-then-read, one iteration of four bursts
    w0 = wst_n; r0 = rstart_n; d0 = done_n;
    start_run(2'd2, 32'h1000, 32'd4, 32'd0, 16'd1, 32'd0);
    wait_pulse(0, "t1_wstart");
    chk("t1_waddr", WADDR_REG, 32'h1000);
    chk("t1_wnburst", WNBURST_REG, 32'd4);
    tick();
    send_b(4);
    wait_pulse(1, "t1_rstart");
    chk("t1_raddr", RADDR_REG, 32'h1000);
    chk("t1_rnburst", RNBURST_REG, 32'd4);
    chk("t1_wrcyc", wr_cycles, 32'd4);
    tick();
    send_r(4);
    wait_done("t1_done", 10, n);
    chk("t1_iter", iter_cnt, 16'd1);
    chk("t1_rdcyc", rd_cycles, 32'd4);
    tick();
    chk("t1_busy", busy, 0);
    chk("t1_nwstart", wst_n - w0, 1);
    chk("t1_nrstart", rstart_n - r0, 1);
    chk("t1_ndone", done_n - d0, 1);

    // Write only, three iterations with stride
    w0 = wst_n; r0 = rstart_n; q0 = waddr_log.size();
    start_run(2'd0, 32'h2000, 32'd1, 32'h400, 16'd3, 32'd0);
    for (int k = 0; k < 3; k++) begin
      wait_pulse(0, "t2_wstart");
      tick();
      send_b(1);
    end
    wait_done("t2_done", 10, n);
    tick();
    chk("t2_nwstart", wst_n - w0, 3);
    if (waddr_log.size() >= q0 + 3) begin
      chk("t2_addr0", waddr_log[q0], 32'h2000);
      chk("t2_addr1", waddr_log[q0+1], 32'h2400);
      chk("t2_addr2", waddr_log[q0+2], 32'h2800);
    end
    chk("t2_nrstart", rstart_n - r0, 0);
    chk("t2_iter", iter_cnt, 16'd3);
    chk("t2_wrcyc", wr_cycles, 32'd3);

    // Read only, final rlast withheld, timeout 100
    w0 = wst_n; d0 = done_n;
    start_run(2'd1, 32'h4000, 32'd2, 32'd0, 16'd1, 32'd100);
    wait_pulse(1, "t3_rstart");
    tick();
    send_r(1);
    wait_done("t3_done", 200, n);
    chk("t3_latency", n + 2, 102);
    chk("t3_err", err_timeout, 1);
    chk("t3_rdcyc", rd_cycles, 32'd100);
    chk("t3_iter", iter_cnt, 16'd0);
    chk("t3_wrcyc", wr_cycles, 32'd0);
    tick();
    chk("t3_nwstart", wst_n - w0, 0);
    chk("t3_ndone", done_n - d0, 1);

    // Zero bursts: both phases skipped
    w0 = wst_n; r0 = rstart_n;
    start_run(2'd2, 32'h6000, 32'd0, 32'd0, 16'd1, 32'd0);
    chk("t4_errclr", err_timeout, 0);
    wait_done("t4_done", 4, n);
    chk("t4_latency", n, 2);
    tick();
    chk("t4_nwstart", wst_n - w0, 0);
    chk("t4_nrstart", rstart_n - r0, 0);
    chk("t4_iter", iter_cnt, 16'd1);

    // Abort coinciding with the final write response
    r0 = rstart_n; d0 = done_n;
    start_run(2'd2, 32'h7000, 32'd2, 32'd0, 16'd1, 32'd0);
    wait_pulse(0, "t5_wstart");
    tick();
    send_b(1);
    bvalid = 1'b1; cfg_abort = 1'b1;
    tick();
    bvalid = 1'b0; cfg_abort = 1'b0;
    wait_done("t5_done", 4, n);
    chk("t5_wrcyc", wr_cycles, 32'd2);
    chk("t5_iter", iter_cnt, 16'd0);
    chk("t5_err", err_timeout, 0);
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_nrstart", rstart_n - r0, 0);
    chk("t5_ndone", done_n - d0, 1);

    // Read idle is not trusted in the first two read cycles
    start_run(2'd1, 32'h8000, 32'd1, 32'd0, 16'd1, 32'd0);
    wait_pulse(1, "t6_rstart");
    tick();
    send_r(1);
    wait_done("t6_done", 10, n);
    chk("t6_rdcyc", rd_cycles, 32'd3);
    tick();

    // Reset in the middle of a write phase
    start_run(2'd0, 32'h9000, 32'd3, 32'd0, 16'd1, 32'd0);
    wait_pulse(0, "t7_wstart");
    tick();
    send_b(1);
    rst = 1'b1;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_wrcyc", wr_cycles, 0);
    chk("t7_waddr", WADDR_REG, 0);
    chk("t7_wnburst", WNBURST_REG, 0);
    chk("t7_iter", iter_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    // Normal run after reset, with a start pulse dropped while busy
    w0 = wst_n; r0 = rstart_n;
    start_run(2'd0, 32'h3000, 32'd2, 32'd0, 16'd1, 32'd0);
    wait_pulse(0, "t8_wstart");
    tick();
    cfg_addr = 32'h5000; cfg_mode = 2'd1; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    send_b(2);
    wait_done("t8_done", 10, n);
    chk("t8_waddr", WADDR_REG, 32'h3000);
    chk("t8_wrcyc", wr_cycles, 32'd3);
    chk("t8_iter", iter_cnt, 16'd1);
    tick();
    chk("t8_nwstart", wst_n - w0, 1);
    chk("t8_nrstart", rstart_n - r0, 0);
    chk("t8_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr_bw_seq.md
Name: ddr_bw_seq

Overview:
- Sequencer for the DDR bandwidth-test AXI master (the write and read engines).
- Programs address and burst count, fires the write phase, the read phase, or write-then-read, and repeats for N iterations with an address stride.
- Detects phase completion by snooping AXI write responses and read last beats, measures cycles per phase, and enforces a timeout.
- Sits between the PS-side register file and the AXI master start/address/burst registers.

Parameters:
- CNT_WIDTH, 32, width of cycle counters and the timeout compare.
- B_BURST_LENGTH, 4, awlen/arlen width; bytes per burst = (2^B_BURST_LENGTH)*DATA_WIDTH/8.
- DATA_WIDTH, 64, AXI data width; used only to compute the default stride.

Ports:
- clk  in  1  single clock, same as the AXI master clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; ignored unless in IDLE.
- cfg_abort  in  1  level; forces ABORT from any busy state.
- cfg_mode  in  2  0 = write only, 1 = read only, 2 = write then read, 3 = reserved (treated as 2).
- cfg_addr  in  32  base byte address.
- cfg_nburst  in  32  bursts per phase; 0 means the phase is skipped.
- cfg_stride  in  32  address increment per iteration.
- cfg_niter  in  16  iteration count; 0 is treated as 1.
- cfg_timeout  in  CNT_WIDTH  max cycles per phase; 0 disables the timeout.
- WSTART_REG, RSTART_REG  out  1  start to the write/read engines.
- WADDR_REG, RADDR_REG  out  32  engine base addresses.
- WNBURST_REG, RNBURST_REG  out  32  engine burst counts.
- RIDLE_REG  in  1  read engine idle.
- bvalid, bready  in  1  snooped m_axi_bvalid / m_axi_bready.
- rvalid, rready, rlast  in  1  snooped read data channel signals.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- err_timeout  out  1  sticky; cleared on cfg_start.
- wr_cycles, rd_cycles  out  CNT_WIDTH  accumulated cycles in WR_RUN and RD_RUN over all iterations.
- iter_cnt  out  16  completed iterations.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- States: IDLE, LOAD, WR_GO, WR_RUN, RD_GO, RD_RUN, NEXT, ABORT.
- IDLE:
  - On cfg_start, latch all cfg_* inputs into shadow registers.
  - Clear wr_cycles, rd_cycles, iter_cnt and err_timeout; current address cur_addr = cfg_addr.
  - Go to LOAD.
- LOAD (1 cycle):
  - Drive W/RADDR_REG = cur_addr and W/RNBURST_REG = nburst; these stay stable until the next LOAD.
  - If the mode includes write and nburst ≠ 0, go to WR_GO.
  - Else if the mode includes read and nburst ≠ 0, go to RD_GO.
  - Else go to NEXT.
- WR_GO (1 cycle):
  - WSTART_REG = 1 for exactly this cycle.
  - Clear the phase counter and the response counter; go to WR_RUN.
- WR_RUN:
  - Count bvalid&bready.
  - Increment wr_cycles and the phase counter every cycle, including the completing cycle.
  - Exit when the count equals nburst: go to RD_GO if the mode includes read, else NEXT.
- RD_GO / RD_RUN: same pattern.
  - RSTART_REG pulses for 1 cycle.
  - Count rvalid&rready&rlast; rd_cycles accumulates.
  - Exit when count == nburst AND RIDLE_REG == 1; RIDLE_REG is ignored during the first 2 cycles of RD_RUN.
  - Go to NEXT.
- NEXT:
  - iter_cnt++ and cur_addr += stride; 32-bit wrap, no saturation.
  - If iter_cnt+1 == niter, pulse done and go to IDLE; else go to LOAD.
- Timeout:
  - In WR_RUN/RD_RUN, if cfg_timeout ≠ 0 and the phase counter reaches cfg_timeout, set err_timeout and go to ABORT.
- ABORT:
  - Deassert start outputs and pulse done; go to IDLE.
  - Counters hold their values.
- cfg_abort has priority over a completion in the same cycle.
- Snooped handshakes arriving in IDLE/LOAD/NEXT are ignored and not counted.
- Counter overflow: wr_cycles and rd_cycles saturate at all-ones.
- A cfg_start pulse while busy is dropped.
- Reset mid-run returns to IDLE immediately. The AXI engines are not reset by this block.

Decomposition:
- Shared package ddr_bw_pkg: state enum, mode encodings (MODE_WR, MODE_RD, MODE_WR_RD), reset constants.
- One sub-module, ddr_bw_phase_cnt: event counter, saturating cycle accumulator and timeout compare. Instantiated twice, once for write and once for read.

Test Plan:
- Mode 2, nburst = 4, niter = 1, addr = 0x1000; model returns 4 B responses, then 4 rlast beats with RIDLE high → WSTART then RSTART each pulse once, W/RADDR_REG = 0x1000, done after the read phase, iter_cnt = 1.
- Mode 0, niter = 3, stride = 0x400, addr = 0x2000 → WADDR_REG sequence 0x2000, 0x2400, 0x2800; RSTART_REG never asserted; iter_cnt = 3.
- Mode 1, nburst = 2; model withholds the final rlast, cfg_timeout = 100 → err_timeout = 1 at phase cycle 100, done pulse, rd_cycles = 100.
- nburst = 0, mode 2 → no start pulses; done within 4 cycles of cfg_start.
- cfg_abort asserted in the same cycle as the final bvalid&bready → ABORT path, done pulse, no RSTART_REG.
- rst asserted mid-WR_RUN → all outputs 0 next edge; a subsequent cfg_start runs normally. A cfg_start pulsed while busy changes nothing.
